gen_waddr_bank_ctrl: RTL and testbench

- Write-side controller for the two-bank (ping-pong) matrix buffer.
- Accepts the incoming data stream with a valid/ready handshake and generates the bank-select, write address and write enable for the buffer RAM.
- Tracks per-bank fullness and publishes ONE_BANK_FULL/TWO_BANK_FULL to the read-side control.
- Frees a bank when the reader pulses READ_ONE_MATRIX.

---
 rtl/gen_waddr_bank_ctrl.sv | 126 ++++++++++++
 tb/tb_gen_waddr_bank_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/gen_waddr_bank_ctrl.sv
// rtl/gen_waddr_bank_ctrl.sv - write-side ping-pong bank controller for the matrix buffer
module gen_waddr_bank_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              SYS_CLK,
    input  logic              SYS_RST,
    input  logic              DIN_VALID,
    input  logic [DATA_W-1:0] DIN,
    output logic              DIN_READY,
    input  logic              READ_ONE_MATRIX,
    output logic              WR_EN,
    output logic              WR_BANK,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              RD_BANK,
    output logic              ONE_BANK_FULL,
    output logic              TWO_BANK_FULL,
    output logic [1:0]        FULL_CNT,
    output logic              RD_UNDERRUN_ERR
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic              wb_q, wb_d;
    logic              rb_q, rb_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [1:0]        full_q, full_d;
    logic [1:0]        full_cnt_q, full_cnt_d;
    logic              err_q, err_d;
    logic              wr_en_q, wr_en_d;
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic accept;
    logic release_ok;

    // Ready depends only on state so DIN_VALID never loops back into DIN_READY.
    always_comb begin
        DIN_READY  = SYS_RST & ~full_q[wb_q];
        accept     = DIN_VALID & DIN_READY;
        release_ok = READ_ONE_MATRIX & full_q[rb_q];
    end

    // Next-state: address/bank advance on accept, bank release on a valid read pulse.
    always_comb begin
        wb_d      = wb_q;
        rb_d      = rb_q;
        waddr_d   = waddr_q;
        full_d    = full_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        // Release is evaluated on the pre-edge full bits; with wb==rb and the bank
        // empty the pulse is an underrun, so the set below can never be undone here.
        if (READ_ONE_MATRIX) begin
            if (release_ok) begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
            end else begin
                err_d = 1'b1;
            end
        end

        if (accept) begin
            wr_en_d   = 1'b1;
            wr_bank_d = wb_q;
            wr_addr_d = waddr_q;
            wr_data_d = DIN;
            if (waddr_q == LAST_ADDR) begin
                waddr_d      = '0;
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end else begin
                waddr_d = waddr_q + 1'b1;
            end
        end

        full_cnt_d = {1'b0, full_d[0]} + {1'b0, full_d[1]};
    end

    // State and registered outputs; reset discards any partially written matrix.
    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST) begin
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            waddr_q    <= '0;
            full_q     <= '0;
            full_cnt_q <= '0;
            err_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_bank_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            waddr_q    <= waddr_d;
            full_q     <= full_d;
            full_cnt_q <= full_cnt_d;
            err_q      <= err_d;
            wr_en_q    <= wr_en_d;
            wr_bank_q  <= wr_bank_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Flags derive from the registered count so they line up with the last word's strobe.
    always_comb begin
        WR_EN           = wr_en_q;
        WR_BANK         = wr_bank_q;
        WR_ADDR         = wr_addr_q;
        WR_DATA         = wr_data_q;
        RD_BANK         = rb_q;
        FULL_CNT        = full_cnt_q;
        ONE_BANK_FULL   = (full_cnt_q != 2'd0);
        TWO_BANK_FULL   = (full_cnt_q == 2'd2);
        RD_UNDERRUN_ERR = err_q;
    end

endmodule

// File: tb/tb_gen_waddr_bank_ctrl.sv
// tb/tb_gen_waddr_bank_ctrl.sv - randomized self-checking bench for gen_waddr_bank_ctrl
module tb_gen_waddr_bank_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int WORDS  = 1 << ADDR_W;

    logic              SYS_CLK = 1'b0;
    logic              SYS_RST = 1'b0;
    logic              DIN_VALID = 1'b0;
    logic [DATA_W-1:0] DIN = '0;
    logic              DIN_READY;
    logic              READ_ONE_MATRIX = 1'b0;
    logic              WR_EN;
    logic              WR_BANK;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic              RD_BANK;
    logic              ONE_BANK_FULL;
    logic              TWO_BANK_FULL;
    logic [1:0]        FULL_CNT;
    logic              RD_UNDERRUN_ERR;

    gen_waddr_bank_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .SYS_CLK         (SYS_CLK),
        .SYS_RST         (SYS_RST),
        .DIN_VALID       (DIN_VALID),
        .DIN             (DIN),
        .DIN_READY       (DIN_READY),
        .READ_ONE_MATRIX (READ_ONE_MATRIX),
        .WR_EN           (WR_EN),
        .WR_BANK         (WR_BANK),
        .WR_ADDR         (WR_ADDR),
        .WR_DATA         (WR_DATA),
        .RD_BANK         (RD_BANK),
        .ONE_BANK_FULL   (ONE_BANK_FULL),
        .TWO_BANK_FULL   (TWO_BANK_FULL),
        .FULL_CNT        (FULL_CNT),
        .RD_UNDERRUN_ERR (RD_UNDERRUN_ERR)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: matrices completed/consumed as counts, plus word position.
    int          m_written  = 0;
    int          m_read     = 0;
    int          m_waddr    = 0;
    logic        m_err      = 1'b0;
    logic        m_en       = 1'b0;
    logic        m_bank     = 1'b0;
    int          m_addr     = 0;
    logic [7:0]  m_data     = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, check ready, advance model, check registered outputs.
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic rst);
        logic m_ready;
        logic acc;
        int   pending;
        DIN_VALID       = v;
        DIN             = d;
        READ_ONE_MATRIX = r;
        SYS_RST         = rst;
        #1;
        pending = m_written - m_read;
        m_ready = rst && (pending < 2);
        check("din_ready", {31'd0, DIN_READY}, {31'd0, m_ready});
        if (!rst) begin
            m_written = 0; m_read = 0; m_waddr = 0; m_err = 1'b0;
            m_en = 1'b0; m_bank = 1'b0; m_addr = 0; m_data = '0;
        end else begin
            acc = v && m_ready;
            if (r) begin
                if (pending > 0) m_read++;
                else m_err = 1'b1;
            end
            if (acc) begin
                m_en   = 1'b1;
                m_bank = m_written[0];
                m_addr = m_waddr;
                m_data = d;
                if (m_waddr == WORDS - 1) begin
                    m_waddr = 0;
                    m_written++;
                end else begin
                    m_waddr++;
                end
            end else begin
                m_en = 1'b0;
            end
        end
        @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        check("wr_en",    {31'd0, WR_EN},           {31'd0, m_en});
        check("wr_bank",  {31'd0, WR_BANK},         {31'd0, m_bank});
        check("wr_addr",  {29'd0, WR_ADDR},         m_addr);
        check("wr_data",  {24'd0, WR_DATA},         {24'd0, m_data});
        check("rd_bank",  {31'd0, RD_BANK},         {31'd0, m_read[0]});
        check("full_cnt", {30'd0, FULL_CNT},        m_written - m_read);
        check("one_full", {31'd0, ONE_BANK_FULL},   {31'd0, (m_written - m_read) != 0});
        check("two_full", {31'd0, TWO_BANK_FULL},   {31'd0, (m_written - m_read) == 2});
        check("underrun", {31'd0, RD_UNDERRUN_ERR}, {31'd0, m_err});
    endtask

    initial begin
        @(negedge SYS_CLK);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Fill both banks with 0x10.. then hold valid against the stall.
        for (int i = 0; i < 2 * WORDS; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h20, 1'b0, 1'b1);
        check("stall_two_full", {31'd0, TWO_BANK_FULL}, 32'd1);

        // Release from two-full; the held word then lands in bank 0 addr 0.
        step(1'b1, 8'h20, 1'b1, 1'b1);
        step(1'b1, 8'h20, 1'b0, 1'b1);
        check("resume_bank", {31'd0, WR_BANK}, 32'd0);
        check("resume_addr", {29'd0, WR_ADDR}, 32'd0);

        // Finish bank 0, release bank 1, fill bank 1 with last word coincident with a read.
        for (int i = 1; i < WORDS; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < WORDS - 1; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b1);
        step(1'b1, 8'h4f, 1'b1, 1'b1);
        check("coincide_cnt", {30'd0, FULL_CNT}, 32'd1);
        check("coincide_rdbank", {31'd0, RD_BANK}, 32'd1);

        // Drain and underrun.
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("underrun_sticky", {31'd0, RD_UNDERRUN_ERR}, 32'd1);

        // Mid-matrix reset with one bank full.
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < WORDS + 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b1);
        step(1'b1, 8'h99, 1'b0, 1'b0);
        check("reset_cnt", {30'd0, FULL_CNT}, 32'd0);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        check("post_reset_addr", {29'd0, WR_ADDR}, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 99) < 70,
                 8'($urandom),
                 $urandom_range(0, 99) < 14,
                 $urandom_range(0, 99) >= 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
